// File: rtl/vpu_src_port_burst_ctrl.sv
// Purpose: expands one operand-read request into a linear burst of SRAM read
// Latency: first request 2 cycles after start, then 1 beat/cycle; data->FIFO same cycle
// Backpressure: issue gated by the outstanding-read credit and the operand FIFO free space
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_i/rvalid_i          start pulse and operand-read enable from the VPU controller
//   raddr_i/rlen_i            burst base address {bank,row} and beat count minus one
//   done_o/busy_o             idle / not-idle status
//   operand_fifo_*            returned read data and write strobe to the operand FIFO
//   fifo_space_i              free entries in the operand FIFO
//   sram_*                    SRAM interconnect read request/response port
module vpu_src_port_burst_ctrl #(
  parameter int BANK_CNT_LG2   = 2,
  parameter int BANK_DEPTH_LG2 = 10,
  parameter int ADDR_WIDTH     = BANK_CNT_LG2 + BANK_DEPTH_LG2,
  parameter int DATA_WIDTH     = 256,
  parameter int MAX_BEATS      = 16,
  parameter int MAX_OUTST      = 4,
  parameter int LEN_W          = $clog2(MAX_BEATS),
  parameter int SPACE_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      rvalid_i,
  input  logic [ADDR_WIDTH-1:0]     raddr_i,
  input  logic [LEN_W-1:0]          rlen_i,
  output logic                      done_o,
  output logic                      busy_o,
  output logic [DATA_WIDTH-1:0]     operand_fifo_wdata_o,
  output logic                      operand_fifo_wren_o,
  input  logic [SPACE_W-1:0]        fifo_space_i,
  output logic                      sram_req_o,
  input  logic                      sram_ack_i,
  output logic [BANK_CNT_LG2-1:0]   sram_rid_o,
  output logic [BANK_DEPTH_LG2-1:0] sram_addr_o,
  output logic                      sram_reb_o,
  output logic                      sram_rlast_o,
  input  logic [DATA_WIDTH-1:0]     sram_rdata_i,
  input  logic                      sram_rvalid_i
);

  localparam int BEAT_W = LEN_W + 1;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [BEAT_W-1:0]         beats_q, beats_d;
  logic [BEAT_W-1:0]         issued_q, issued_d;
  logic [BEAT_W-1:0]         returned_q, returned_d;
  logic [OUT_W-1:0]          outst_q, outst_d;
  logic                      req_q, req_d;
  logic [BANK_CNT_LG2-1:0]   rid_q, rid_d;
  logic [BANK_DEPTH_LG2-1:0] addr_q, addr_d;
  logic                      reb_q, reb_d;
  logic                      rlast_q, rlast_d;

  logic             ack;
  logic             rsp;
  logic [OUT_W-1:0] outst_nxt;
  logic             elig;

  assign ack = req_q & sram_ack_i;
  // Responses arriving while idle belong to an aborted burst and are discarded.
  assign rsp = sram_rvalid_i & (state_q != IDLE);

  // Credit check uses the count as it will stand after this edge, so an ack
  // retires its own request into the outstanding count before the next beat
  // is judged, and a same-cycle response frees its slot immediately.
  assign outst_nxt = outst_q + OUT_W'(ack) - OUT_W'(rsp);
  assign elig      = (int'(outst_nxt) < MAX_OUTST) && (int'(outst_nxt) < int'(fifo_space_i));

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beats_d    = beats_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_nxt;
    req_d      = req_q;
    rid_d      = rid_q;
    addr_d     = addr_q;
    reb_d      = reb_q;
    rlast_d    = rlast_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && rvalid_i) begin
          cur_addr_d = raddr_i;
          beats_d    = BEAT_W'(rlen_i) + BEAT_W'(1);
          issued_d   = '0;
          returned_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (ack) begin
          issued_d = issued_q + BEAT_W'(1);
        end
        // Request fields may only change when nothing is pending or the
        // pending beat is being accepted; otherwise they hold.
        if (!req_q || ack) begin
          if ((issued_d < beats_q) && elig) begin
            req_d            = 1'b1;
            reb_d            = 1'b0;
            {rid_d, addr_d}  = cur_addr_q;
            rlast_d          = (issued_d == beats_q - BEAT_W'(1));
            // Plain binary increment: row overflow carries into bank and the
            // top address wraps to zero.
            cur_addr_d       = cur_addr_q + ADDR_WIDTH'(1);
          end else begin
            req_d   = 1'b0;
            reb_d   = 1'b1;
            rid_d   = '0;
            addr_d  = '0;
            rlast_d = 1'b0;
          end
        end
        if (ack && (issued_d == beats_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rsp) begin
      returned_d = returned_q + BEAT_W'(1);
      if ((state_q == DRAIN) && (returned_d == beats_q)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      beats_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      req_q      <= 1'b0;
      rid_q      <= '0;
      addr_q     <= '0;
      reb_q      <= 1'b1;
      rlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      beats_q    <= beats_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      req_q      <= req_d;
      rid_q      <= rid_d;
      addr_q     <= addr_d;
      reb_q      <= reb_d;
      rlast_q    <= rlast_d;
    end
  end

  assign done_o               = (state_q == IDLE);
  assign busy_o               = (state_q != IDLE);
  assign operand_fifo_wren_o  = rsp;
  assign operand_fifo_wdata_o = sram_rdata_i;
  assign sram_req_o           = req_q;
  assign sram_rid_o           = rid_q;
  assign sram_addr_o          = addr_q;
  assign sram_reb_o           = reb_q;
  assign sram_rlast_o         = rlast_q;

  a_rsp_has_outst: assert property (@(posedge clk) disable iff (rst)
    (sram_rvalid_i && (state_q != IDLE)) |-> (outst_q != '0));
  a_wren_has_space: assert property (@(posedge clk) disable iff (rst)
    operand_fifo_wren_o |-> (fifo_space_i != '0));
  a_outst_bound: assert property (@(posedge clk) disable iff (rst)
    int'(outst_q) <= MAX_OUTST);

endmodule

// File: tb/tb_vpu_src_port_burst_ctrl.sv
// Purpose: scoreboard bench for the VPU source-port burst read controller
// Latency: n/a (bench)
// Backpressure: SRAM model with programmable ack delay / response latency
module tb_vpu_src_port_burst_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         rvalid_i = 1'b0;
  logic [11:0]  raddr_i = '0;
  logic [3:0]   rlen_i = '0;
  logic         done_o, busy_o;
  logic [255:0] operand_fifo_wdata_o;
  logic         operand_fifo_wren_o;
  logic [7:0]   fifo_space_i = 8'd16;
  logic         sram_req_o;
  logic         sram_ack_i = 1'b0;
  logic [1:0]   sram_rid_o;
  logic [9:0]   sram_addr_o;
  logic         sram_reb_o, sram_rlast_o;
  logic [255:0] sram_rdata_i = '0;
  logic         sram_rvalid_i = 1'b0;

  always #5 clk = ~clk;

  vpu_src_port_burst_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rvalid_i(rvalid_i),
    .raddr_i(raddr_i), .rlen_i(rlen_i), .done_o(done_o), .busy_o(busy_o),
    .operand_fifo_wdata_o(operand_fifo_wdata_o), .operand_fifo_wren_o(operand_fifo_wren_o),
    .fifo_space_i(fifo_space_i), .sram_req_o(sram_req_o), .sram_ack_i(sram_ack_i),
    .sram_rid_o(sram_rid_o), .sram_addr_o(sram_addr_o), .sram_reb_o(sram_reb_o),
    .sram_rlast_o(sram_rlast_o), .sram_rdata_i(sram_rdata_i), .sram_rvalid_i(sram_rvalid_i)
  );

  typedef struct packed {
    logic [1:0] rid;
    logic [9:0] addr;
    logic       rlast;
  } req_t;

  int n_cmp = 0;
  int n_bad = 0;

  req_t         exp_req[$];
  logic [255:0] exp_dat[$];
  logic [255:0] pend_dat[$];
  int           pend_due[$];

  int   ack_delay = 0;
  int   rv_lat    = 2;
  int   wait_cnt  = 0;
  int   cyc       = 0;
  int   out_m     = 0;
  int   max_out   = 0;
  int   ack_cnt   = 0;
  int   rv_cnt    = 0;
  int   wren_cnt  = 0;
  int   first_ack = -1;
  int   last_ack  = -1;
  req_t mon_cur;
  logic mon_ack, mon_rv;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] dat_of(input logic [11:0] a);
    return {8{20'hC0DE0, a}};
  endfunction

  // SRAM model and request monitor: decides ack at the falling edge (the
  // DUT samples it on the next rising edge) and returns data rv_lat cycles later.
  always @(negedge clk) begin
    cyc++;
    mon_ack       = 1'b0;
    mon_rv        = 1'b0;
    sram_ack_i    = 1'b0;
    sram_rvalid_i = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      mon_rv        = 1'b1;
      sram_rvalid_i = 1'b1;
      sram_rdata_i  = pend_dat.pop_front();
      void'(pend_due.pop_front());
      rv_cnt++;
    end
    if (rst) begin
      wait_cnt = 0;
      out_m    = 0;
    end else begin
      mon_cur = {sram_rid_o, sram_addr_o, sram_rlast_o};
      if (sram_req_o) begin
        chk("reb_low_during_req", 256'(sram_reb_o), 256'(0));
        chk("req_expected", 256'(exp_req.size() > 0), 256'(1));
        if (exp_req.size() > 0) chk("req_fields", 256'(mon_cur), 256'(exp_req[0]));
        if (wait_cnt >= ack_delay) begin
          mon_ack    = 1'b1;
          sram_ack_i = 1'b1;
          wait_cnt   = 0;
          ack_cnt++;
          if (exp_req.size() > 0) void'(exp_req.pop_front());
          pend_dat.push_back(dat_of({sram_rid_o, sram_addr_o}));
          pend_due.push_back(cyc + rv_lat);
          if (first_ack < 0) first_ack = cyc;
          last_ack = cyc;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        chk("idle_bus_fields", 256'({sram_reb_o, mon_cur}), 256'({1'b1, 13'b0}));
      end
      if (mon_ack) out_m++;
      if (mon_rv && out_m > 0) out_m--;
      if (out_m > max_out) max_out = out_m;
    end
  end

  // FIFO-side monitor: every write must match the next expected beat.
  always @(negedge clk) begin
    #1;
    if (!rst && operand_fifo_wren_o) begin
      wren_cnt++;
      chk("wren_expected", 256'(exp_dat.size() > 0), 256'(1));
      if (exp_dat.size() > 0) chk("wdata", operand_fifo_wdata_o, exp_dat.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_burst(input logic [11:0] base, input int rlen);
    logic [11:0] a;
    for (int i = 0; i <= rlen; i++) begin
      a = base + 12'(i);
      exp_req.push_back({a[11:10], a[9:0], (i == rlen)});
      exp_dat.push_back(dat_of(a));
    end
    start_i  = 1'b1;
    rvalid_i = 1'b1;
    raddr_i  = base;
    rlen_i   = 4'(rlen);
    step();
    start_i  = 1'b0;
    rvalid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (!(done_o && exp_req.size() == 0 && exp_dat.size() == 0 && pend_due.size() == 0)
           && k < budget) begin
      step();
      k++;
    end
    chk({nm, "_in_time"}, 256'(k < budget), 256'(1));
    chk({nm, "_done_busy"}, 256'({done_o, busy_o}), 256'(2'b10));
  endtask

  initial begin
    int base_ack, base_rv, base_wren, k;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_ack, base_rv, base_wren, k;
    // 1: reset and idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_outputs", 256'({sram_req_o, sram_reb_o, sram_rlast_o, done_o, busy_o}), 256'(5'b01010));
    start_i  = 1'b1;
    rvalid_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_without_rvalid", 256'({done_o, busy_o, sram_req_o}), 256'(3'b100));
      step();
    end

    // 2: single beat {bank2,row5}
    ack_delay = 1;
    rv_lat    = 2;
    issue_burst({2'd2, 10'd5}, 0);
    wait_done("single_beat", 50);

    // 3: 8 beats, slow returns so the credit limit of 4 is reached
    ack_delay = 0;
    rv_lat    = 6;
    max_out   = 0;
    issue_burst(12'h000, 7);
    wait_done("credit_burst", 200);
    chk("credit_limit_max_out", 256'(max_out), 256'(4));

    // 4: row/bank wrap
    rv_lat = 2;
    issue_burst({2'd1, 10'd1023}, 2);
    wait_done("row_to_bank_wrap", 100);
    issue_burst({2'd3, 10'd1023}, 1);
    wait_done("top_addr_wrap", 100);

    // 5: FIFO space of 1, slow ack (fields must hold while waiting)
    fifo_space_i = 8'd1;
    ack_delay    = 3;
    rv_lat       = 2;
    max_out      = 0;
    issue_burst(12'h0A0, 3);
    wait_done("space_one", 200);
    chk("space_one_max_out", 256'(max_out), 256'(1));

    // 5b: ack and response in the same cycle keep 1 beat/cycle
    fifo_space_i = 8'd16;
    ack_delay    = 0;
    rv_lat       = 1;
    max_out      = 0;
    first_ack    = -1;
    issue_burst(12'h123, 3);
    wait_done("ack_rv_overlap", 100);
    chk("overlap_ack_span", 256'(last_ack - first_ack), 256'(3));
    chk("overlap_max_out", 256'(max_out), 256'(1));

    // 6: reset after 2 of 6 acks; late responses must be dropped
    rv_lat    = 3;
    base_ack  = ack_cnt;
    base_rv   = rv_cnt;
    issue_burst(12'h200, 5);
    k = 0;
    while (ack_cnt < base_ack + 2 && k < 50) begin
      step();
      k++;
    end
    chk("midburst_two_acks", 256'(k < 50), 256'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midburst_reset_outputs",
        256'({sram_req_o, sram_reb_o, sram_rlast_o, done_o, busy_o, sram_rid_o, sram_addr_o}),
        256'({5'b01010, 12'h000}));
    exp_req.delete();
    exp_dat.delete();
    base_wren = wren_cnt;
    k = 0;
    while (pend_due.size() > 0 && k < 20) begin
      step();
      k++;
    end
    step();
    chk("late_rvalid_seen", 256'(rv_cnt - base_rv), 256'(2));
    chk("late_rvalid_dropped", 256'(wren_cnt - base_wren), 256'(0));
    chk("idle_after_late_rvalid", 256'({done_o, busy_o}), 256'(2'b10));
    issue_burst(12'h3FE, 3);
    wait_done("after_reset_burst", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
